// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Avalon-style memory port between the instruction-fetch
// requester and the data requester. One transaction is in flight at a time. The granted
// requester gets a one-cycle ack, together with the read data for loads and fetches.
module mem_bus_arbiter #(
   parameter bit          DATA_PRIORITY = 1'b1,  // 1: data wins ties, 0: round-robin on ties
   parameter int unsigned WAIT_TIMEOUT  = 0      // waitrequest cycles before abort, 0 = never
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_ack_o,
   input  logic        data_req_i,
   input  logic        data_write_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   input  logic [3:0]  data_byte_en_i,
   output logic        data_ack_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic [31:0] avm_address_o,
   output logic        avm_read_o,
   output logic        avm_write_o,
   output logic [31:0] avm_writedata_o,
   output logic [3:0]  avm_byteenable_o,
   input  logic        avm_waitrequest_i,
   input  logic [31:0] avm_readdata_i
);

   typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_e;

   localparam int unsigned CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);
   localparam bit TIMEOUT_EN = (WAIT_TIMEOUT != 0);

   state_e            state_q, state_d;
   logic              grant_data_q;       // requester owning the current transaction
   logic              last_grant_data_q;  // requester granted most recently
   logic [31:0]       addr_q;
   logic              write_q;
   logic [31:0]       wdata_q;
   logic [3:0]        be_q;
   logic              rd_stb_q;
   logic              wr_stb_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic [CNT_W-1:0]  wait_cnt_q;

   logic any_req;
   logic pick_data;
   logic accepted;
   logic timeout_hit;

   assign any_req     = instr_req_i | data_req_i;
   assign accepted    = (rd_stb_q | wr_stb_q) & ~avm_waitrequest_i;
   // The cycle that would take the counter to WAIT_TIMEOUT aborts the command.
   assign timeout_hit = TIMEOUT_EN & avm_waitrequest_i & (wait_cnt_q == TO_LAST);

   // Winner selection among the requests visible in IDLE.
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
      pick_data = data_req_i;
      if (instr_req_i && data_req_i) begin
         pick_data = DATA_PRIORITY ? 1'b1 : ~last_grant_data_q;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (any_req) state_d = CMD;
         CMD: begin
            if (accepted)         state_d = write_q ? DONE : RESP;
            else if (timeout_hit) state_d = DONE;
         end
         RESP:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: acks and error flag are decoded from the DONE state.
   always_comb begin
      instr_ack_o = 1'b0;
      data_ack_o  = 1'b0;
      err_o       = 1'b0;
      if (state_q == DONE) begin
         instr_ack_o = ~grant_data_q;
         data_ack_o  = grant_data_q;
         err_o       = err_q;
      end
   end

   // Request latch, registered bus strobes, timeout counter and read-data capture.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         grant_data_q      <= 1'b0;
         last_grant_data_q <= 1'b1;
         addr_q            <= '0;
         write_q           <= 1'b0;
         wdata_q           <= '0;
         be_q              <= '0;
         rd_stb_q          <= 1'b0;
         wr_stb_q          <= 1'b0;
         rdata_q           <= '0;
         err_q             <= 1'b0;
         wait_cnt_q        <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_data_q      <= pick_data;
                  last_grant_data_q <= pick_data;
                  addr_q            <= pick_data ? data_addr_i    : instr_addr_i;
                  write_q           <= pick_data & data_write_i;
                  wdata_q           <= pick_data ? data_wdata_i   : 32'h0;
                  be_q              <= pick_data ? data_byte_en_i : 4'b1111;
                  rd_stb_q          <= ~(pick_data & data_write_i);
                  wr_stb_q          <= pick_data & data_write_i;
                  err_q             <= 1'b0;
                  wait_cnt_q        <= '0;
               end
            end
            CMD: begin
               if (accepted) begin
                  rd_stb_q <= 1'b0;
                  wr_stb_q <= 1'b0;
               end else if (timeout_hit) begin
                  rd_stb_q <= 1'b0;
                  wr_stb_q <= 1'b0;
                  err_q    <= 1'b1;
               end else if (avm_waitrequest_i) begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            RESP:    rdata_q <= avm_readdata_i;
            default: ;
         endcase
      end
   end

   assign avm_address_o    = addr_q;
   assign avm_read_o       = rd_stb_q;
   assign avm_write_o      = wr_stb_q;
   assign avm_writedata_o  = wdata_q;
   assign avm_byteenable_o = be_q;
   assign rdata_o          = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter. The main instance (data priority, timeout 8) runs directed
// scenarios and a randomized transaction stream against a transaction-level model; a
// second instance (round-robin, no timeout) shows the alternating tie grants.
module tb_mem_bus_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr_addr;
   logic        data_write;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_be;
   logic        waitreq;
   logic [31:0] readdata;

   logic        m_ireq, m_dreq, m_iack, m_dack, m_err, m_read, m_write;
   logic [31:0] m_rdata, m_addr, m_wdata;
   logic [3:0]  m_be;
   logic        r_ireq, r_dreq, r_iack, r_dack, r_err, r_read, r_write;
   logic [31:0] r_rdata, r_addr, r_wdata;
   logic [3:0]  r_be;

   int vectors    = 0;
   int miscompares = 0;

   // Transaction-level model state.
   bit          ipend, dpend;
   logic [31:0] rdata_model;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.DATA_PRIORITY(1'b1), .WAIT_TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .instr_req_i(m_ireq), .instr_addr_i(instr_addr), .instr_ack_o(m_iack),
      .data_req_i(m_dreq), .data_write_i(data_write), .data_addr_i(data_addr),
      .data_wdata_i(data_wdata), .data_byte_en_i(data_be), .data_ack_o(m_dack),
      .rdata_o(m_rdata), .err_o(m_err),
      .avm_address_o(m_addr), .avm_read_o(m_read), .avm_write_o(m_write),
      .avm_writedata_o(m_wdata), .avm_byteenable_o(m_be),
      .avm_waitrequest_i(waitreq), .avm_readdata_i(readdata)
   );

   mem_bus_arbiter #(.DATA_PRIORITY(1'b0), .WAIT_TIMEOUT(0)) dut_rr (
      .clk_i(clk), .rst_n_i(rst_n),
      .instr_req_i(r_ireq), .instr_addr_i(instr_addr), .instr_ack_o(r_iack),
      .data_req_i(r_dreq), .data_write_i(data_write), .data_addr_i(data_addr),
      .data_wdata_i(data_wdata), .data_byte_en_i(data_be), .data_ack_o(r_dack),
      .rdata_o(r_rdata), .err_o(r_err),
      .avm_address_o(r_addr), .avm_read_o(r_read), .avm_write_o(r_write),
      .avm_writedata_o(r_wdata), .avm_byteenable_o(r_be),
      .avm_waitrequest_i(waitreq), .avm_readdata_i(readdata)
   );

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Serve the transaction the model says wins next. waits = waitrequest-high cycles the
   // bus inserts; hold = the fetch requester keeps its request up after its ack.
   task automatic serve(input int waits, input logic [31:0] rd, input bit hold);
      bit          win_data, wr, tout;
      logic [31:0] ex_addr, ex_wd;
      logic [3:0]  ex_be;
      int          strobe_last, ack_c;
      win_data    = dpend;                     // data always wins with data priority
      wr          = win_data && data_write;
      ex_addr     = win_data ? data_addr : instr_addr;
      ex_be       = win_data ? data_be : 4'hF;
      ex_wd       = data_wdata;
      tout        = (waits >= TO);
      strobe_last = tout ? TO : waits + 1;
      ack_c       = tout ? TO + 1 : (wr ? waits + 2 : waits + 3);
      @(negedge clk);
      m_ireq  = ipend;
      m_dreq  = dpend;
      waitreq = 1'b0;
      check1("idle_iack", m_iack, 1'b0);
      check1("idle_dack", m_dack, 1'b0);
      check1("idle_read", m_read, 1'b0);
      check1("idle_write", m_write, 1'b0);
      for (int c = 1; c <= ack_c; c++) begin
         @(negedge clk);
         waitreq  = (c <= waits);
         readdata = (c == waits + 2) ? rd : $urandom;
         check1("read_strobe", m_read, !wr && c <= strobe_last);
         check1("write_strobe", m_write, wr && c <= strobe_last);
         if (c <= strobe_last) begin
            check32("bus_addr", m_addr, ex_addr);
            check32("bus_be", {28'h0, m_be}, {28'h0, ex_be});
            if (wr) check32("bus_wdata", m_wdata, ex_wd);
         end
         check1("instr_ack", m_iack, c == ack_c && !win_data);
         check1("data_ack", m_dack, c == ack_c && win_data);
         check1("err", m_err, c == ack_c && tout);
         if (c == ack_c && !wr) begin
            if (!tout) rdata_model = rd;
            check32("rdata", m_rdata, rdata_model);
         end
      end
      waitreq = 1'b0;
      if (win_data) dpend = 1'b0;
      else if (!hold) ipend = 1'b0;
      m_ireq = ipend;
      m_dreq = dpend;
   endtask

   initial begin
      int  w;
      int  got;
      bit  last_d, exp_d;
      rst_n = 1'b0;
      m_ireq = 1'b0; m_dreq = 1'b0; r_ireq = 1'b0; r_dreq = 1'b0;
      ipend = 1'b0; dpend = 1'b0; rdata_model = 32'h0;
      instr_addr = 32'h0; data_write = 1'b0; data_addr = 32'h0;
      data_wdata = 32'h0; data_be = 4'h0; waitreq = 1'b0; readdata = 32'h0;

      // Reset state.
      #1;
      check1("rst_iack", m_iack, 1'b0);
      check1("rst_dack", m_dack, 1'b0);
      check1("rst_err", m_err, 1'b0);
      check1("rst_read", m_read, 1'b0);
      check1("rst_write", m_write, 1'b0);
      check32("rst_rdata", m_rdata, 32'h0);
      check32("rst_addr", m_addr, 32'h0);
      check32("rst_wdata", m_wdata, 32'h0);
      check32("rst_be", {28'h0, m_be}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Minimum-latency fetch.
      instr_addr = 32'hBFC0_0000; ipend = 1'b1;
      serve(0, 32'h2402_0005, 1'b0);

      // Store with three wait cycles.
      data_write = 1'b1; data_addr = 32'h0000_1000; data_wdata = 32'hDEAD_BEEF;
      data_be = 4'b1100; dpend = 1'b1;
      serve(3, 32'h0, 1'b0);

      // Simultaneous requests: data first, then fetch.
      instr_addr = 32'h0000_0040; ipend = 1'b1;
      data_write = 1'b0; data_addr = 32'h0000_2000; data_be = 4'b0011; dpend = 1'b1;
      serve(0, 32'h1234_5678, 1'b0);
      serve(1, 32'h9ABC_DEF0, 1'b0);

      // Stuck waitrequest aborts with err; the next request completes cleanly.
      instr_addr = 32'h0000_0080; ipend = 1'b1;
      serve(12, 32'h0, 1'b0);
      data_write = 1'b1; data_addr = 32'h0000_3000; data_wdata = 32'h0BAD_F00D;
      data_be = 4'hF; dpend = 1'b1;
      serve(0, 32'h0, 1'b0);

      // Held fetch request gives two separate transactions.
      instr_addr = 32'h0000_0100; ipend = 1'b1;
      serve(0, 32'hAAAA_0001, 1'b1);
      serve(0, 32'hAAAA_0002, 1'b0);

      // Reset during the command phase of a read.
      @(negedge clk);
      instr_addr = 32'h0000_0200; m_ireq = 1'b1; waitreq = 1'b1;
      @(negedge clk);
      check1("pre_rst_read", m_read, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check1("mid_rst_read", m_read, 1'b0);
      check1("mid_rst_iack", m_iack, 1'b0);
      check32("mid_rst_rdata", m_rdata, 32'h0);
      m_ireq = 1'b0; waitreq = 1'b0;
      rdata_model = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check1("post_rst_iack", m_iack, 1'b0);
         check1("post_rst_read", m_read, 1'b0);
      end
      instr_addr = 32'h0000_0300; ipend = 1'b1;
      serve(0, 32'h5555_AAAA, 1'b0);

      // Randomized transaction stream.
      for (int n = 0; n < 40; n++) begin
         if (!ipend && $urandom_range(0, 1) == 1) begin
            instr_addr = $urandom & ~32'h3;
            ipend = 1'b1;
         end
         if (!dpend && ($urandom_range(0, 1) == 1 || !ipend)) begin
            data_write = 1'($urandom_range(0, 1));
            data_addr  = $urandom;
            data_wdata = $urandom;
            data_be    = 4'($urandom_range(1, 15));
            dpend = 1'b1;
         end
         w = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
         serve(w, $urandom, 1'b0);
      end
      if (ipend || dpend) serve(0, $urandom, 1'b0);
      if (ipend || dpend) serve(0, $urandom, 1'b0);

      // Round-robin instance: both requests held, grants alternate starting with fetch.
      @(negedge clk);
      instr_addr = 32'h0000_0400; data_write = 1'b0; data_addr = 32'h0000_5000;
      data_be = 4'hF; waitreq = 1'b0; readdata = 32'h7777_0000;
      r_ireq = 1'b1; r_dreq = 1'b1;
      last_d = 1'b1; got = 0;
      for (int c = 0; c < 60 && got < 4; c++) begin
         @(negedge clk);
         if (r_iack || r_dack) begin
            exp_d = !last_d;
            check1("rr_data_ack", r_dack, exp_d);
            check1("rr_instr_ack", r_iack, !exp_d);
            check1("rr_err", r_err, 1'b0);
            last_d = exp_d;
            got++;
         end
      end
      check32("rr_ack_count", 32'(got), 32'd4);
      r_ireq = 1'b0; r_dreq = 1'b0;
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
